fir_sequencer: RTL and testbench

Sample-level controller that sits in front of `fir_filter` and sequences it. It accepts samples over a valid/ready handshake and drives the filter's `buff_en`, `fir_en` and `fir_data` for one shift per accepted sample. It captures `fir_filtered_data` after the filter latency and presents it on a valid/ready output port. Outputs are suppressed until the delay line is primed, and a flush command drains the filter with zeros.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_seq_counter.sv | 22 ++
 rtl/fir_sequencer.sv | 121 ++++++++++++
 tb/tb_fir_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, filter latency and sequencer state encoding for the FIR datapath
package fir_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int OUT_W_DEF   = 32;
    localparam int TAPS_DEF    = 8;
    localparam int FIR_LAT_DEF = 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE        = 3'd0;
    localparam state_t S_WAIT_IN     = 3'd1;
    localparam state_t S_SHIFT       = 3'd2;
    localparam state_t S_COMPUTE     = 3'd3;
    localparam state_t S_HOLD        = 3'd4;
    localparam state_t S_FLUSH_SHIFT = 3'd5;
    localparam state_t S_FLUSH_WAIT  = 3'd6;

endpackage

// File: rtl/fir_seq_counter.sv
// fir_seq_counter: loadable down-counter with zero flag; load wins over decrement and it never wraps below zero
module fir_seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    // load or count down, holding at zero
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (load) count <= load_val;
        else if (dec && count != '0) count <= count - W'(1);

    assign zero = count == '0;

endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: valid/ready front end that strobes fir_filter once per sample and returns primed results
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int TAPS    = TAPS_DEF,
    parameter int FIR_LAT = FIR_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fir_buff_en,
    output logic              fir_en,
    output logic [DATA_W-1:0] fir_data,
    input  logic [OUT_W-1:0]  fir_filtered_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              primed,
    output logic              busy
);

    localparam int CW = $clog2(TAPS) + 1;
    localparam int FW = $clog2(TAPS + 1);
    localparam int LW = $clog2(FIR_LAT + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(TAPS - 1);
    localparam logic [CW-1:0] FILL_MAX  = CW'(TAPS);

    state_t        state, state_n;
    logic [CW-1:0] fill_cnt;
    logic [LW-1:0] lat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          lat_zero, flush_zero, pend;
    logic          last_lat, take, capture, flush_start, flush_done;
    logic          unused_cnt;

    assign last_lat    = lat_cnt == LW'(1);
    assign take        = state == S_WAIT_IN && in_valid;
    assign capture     = state == S_COMPUTE && last_lat;
    assign flush_start = state_n == S_FLUSH_SHIFT && (state == S_IDLE || state == S_WAIT_IN);
    assign flush_done  = state == S_FLUSH_WAIT && last_lat && flush_zero;
    assign unused_cnt  = ^{lat_zero, flush_cnt};

    assign in_ready    = state == S_WAIT_IN;
    assign fir_buff_en = state == S_SHIFT || state == S_FLUSH_SHIFT;
    assign fir_en      = state != S_IDLE;
    assign busy        = state != S_IDLE;
    assign out_valid   = state == S_HOLD;
    assign primed      = fill_cnt >= FILL_MAX;

    // filter latency, reused for the gaps between flush strobes
    fir_seq_counter #(.W(LW)) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (state == S_SHIFT || state == S_FLUSH_SHIFT),
        .dec      (state == S_COMPUTE || state == S_FLUSH_WAIT),
        .load_val (LW'(FIR_LAT)),
        .count    (lat_cnt),
        .zero     (lat_zero)
    );

    // zeros still to push during a flush
    fir_seq_counter #(.W(FW)) u_flush (
        .clk      (clk),
        .reset    (reset),
        .load     (flush_start),
        .dec      (state == S_FLUSH_SHIFT),
        .load_val (FW'(TAPS)),
        .count    (flush_cnt),
        .zero     (flush_zero)
    );

    // next state; an accepted sample always beats a flush in WAIT_IN
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:        state_n = flush_req ? S_FLUSH_SHIFT : enable ? S_WAIT_IN : S_IDLE;
            S_WAIT_IN:     state_n = in_valid ? S_SHIFT : (flush_req || pend) ? S_FLUSH_SHIFT : !enable ? S_IDLE : S_WAIT_IN;
            S_SHIFT:       state_n = S_COMPUTE;
            S_COMPUTE:     state_n = !last_lat ? S_COMPUTE : fill_cnt >= FILL_LAST ? S_HOLD : S_WAIT_IN;
            S_HOLD:        state_n = out_ready ? S_WAIT_IN : S_HOLD;
            S_FLUSH_SHIFT: state_n = S_FLUSH_WAIT;
            S_FLUSH_WAIT:  state_n = !last_lat ? S_FLUSH_WAIT : flush_zero ? S_IDLE : S_FLUSH_SHIFT;
            default:       state_n = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= state_n;

    // sample register feeding the filter; forced to zero for the whole flush
    always_ff @(posedge clk or negedge reset)
        if (!reset) fir_data <= '0;
        else if (take) fir_data <= in_data;
        else if (flush_start) fir_data <= '0;

    // result capture and saturating count of filled taps
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            out_data <= '0;
            fill_cnt <= '0;
        end else begin
            if (capture) out_data <= fir_filtered_data;
            if (flush_done) fill_cnt <= '0;
            else if (capture && fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + CW'(1);
        end

    // a flush asked for while a sample is in flight waits for the next WAIT_IN
    always_ff @(posedge clk or negedge reset)
        if (!reset) pend <= 1'b0;
        else if (flush_done) pend <= 1'b0;
        else if (flush_req && (take || state == S_SHIFT || state == S_COMPUTE || state == S_HOLD)) pend <= 1'b1;

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed checks of fir_sequencer against an 8-tap unity-coefficient filter stand-in
module tb_fir_sequencer;
  localparam int DW = 16;
  localparam int OW = 32;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          flush_req = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, fir_buff_en, fir_en, out_valid, primed, busy;
  logic [DW-1:0] fir_data;
  logic [OW-1:0] fir_filtered_data, out_data;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int zpulses = 0;
  int n, p0, z0, acc;
  logic ov;
  logic signed [DW-1:0] taps [8];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  fir_sequencer #(.DATA_W(DW), .OUT_W(OW), .TAPS(8), .FIR_LAT(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .flush_req         (flush_req),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .fir_buff_en       (fir_buff_en),
    .fir_en            (fir_en),
    .fir_data          (fir_data),
    .fir_filtered_data (fir_filtered_data),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready),
    .primed            (primed),
    .busy              (busy)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) taps[k] <= '0;
      fir_filtered_data <= '0;
    end else if (fir_buff_en) begin
      acc = int'($signed(fir_data));
      for (int k = 0; k < 7; k++) acc += int'(taps[k]);
      for (int k = 7; k > 0; k--) taps[k] <= taps[k-1];
      taps[0] <= fir_data;
      fir_filtered_data <= acc;
    end
  end

  always @(posedge clk) begin
    if (fir_buff_en) begin
      pulses <= pulses + 1;
      if (fir_data == '0) zpulses <= zpulses + 1;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_flags", {in_ready, fir_buff_en, fir_en, out_valid, primed, busy} === 6'd0);
    chk("rst_fir_data", fir_data === 16'h0000);
    chk("rst_out_data", out_data === 32'h0000_0000);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready === 1'b1);
    chk("rel_busy_en", {busy, fir_en} === 2'b11);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 16'h7FFF;
      @(negedge clk);
      in_valid = 1'b0;
      chk("prime_strobe", {fir_buff_en, in_ready} === 2'b10);
      chk("prime_fir_data", fir_data === 16'h7FFF);
      @(negedge clk);
      chk("prime_compute", {fir_buff_en, out_valid, primed} === 3'b000);
      @(negedge clk);
      if (i < 7) chk("prime_discard", {out_valid, in_ready} === 2'b01);
    end
    chk("prime_valid", {out_valid, in_ready, primed} === 3'b101);
    chk("prime_out_data", out_data === 32'h0003_FFF8);
    p0 = pulses;
    in_valid = 1'b1;
    in_data = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, fir_buff_en} === 3'b100);
      chk("bp_out_data", out_data === 32'h0003_FFF8);
    end
    chk("bp_no_strobe", pulses - p0 === 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready} === 2'b01);
    in_valid = 1'b1;
    in_data = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_t1", {fir_buff_en, in_ready, out_valid} === 3'b100);
    chk("lat_t1_data", fir_data === 16'h0001);
    @(negedge clk);
    chk("lat_t2", {fir_buff_en, out_valid} === 2'b00);
    @(negedge clk);
    chk("lat_t3", {out_valid, in_ready} === 2'b10);
    chk("lat_t3_data", out_data === 32'h0003_7FFA);
    @(negedge clk);
    chk("lat_t4", {in_ready, out_valid} === 2'b10);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_hold_data", out_data === 32'h0002_FFFA);
    chk("fl_hold_valid", out_valid === 1'b1);
    flush_req = 1'b1;
    p0 = pulses;
    z0 = zpulses;
    @(negedge clk);
    flush_req = 1'b0;
    chk("fl_still_hold", {out_valid, busy, fir_buff_en} === 3'b110);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("fl_wait_in", {in_ready, out_valid} === 2'b10);
    n = 0;
    ov = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      ov |= out_valid;
      if (!busy) break;
    end
    chk("fl_cycles", n === 17);
    chk("fl_pulses", pulses - p0 === 8);
    chk("fl_zero_pulses", zpulses - z0 === 8);
    chk("fl_no_valid", ov === 1'b0);
    chk("fl_idle", {primed, fir_en, in_ready} === 3'b000);
    @(negedge clk);
    chk("col_wait_in", in_ready === 1'b1);
    in_valid = 1'b1;
    in_data = 16'h0005;
    flush_req = 1'b1;
    p0 = pulses;
    z0 = zpulses;
    @(negedge clk);
    in_valid = 1'b0;
    flush_req = 1'b0;
    chk("col_sample_first", {fir_buff_en, fir_data} === {1'b1, 16'h0005});
    @(negedge clk);
    @(negedge clk);
    chk("col_back_wait_in", {in_ready, out_valid} === 2'b10);
    @(negedge clk);
    chk("col_flush_strobe", {fir_buff_en, fir_data} === {1'b1, 16'h0000});
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    chk("col_cycles", n === 16);
    chk("col_pulses", pulses - p0 === 9);
    chk("col_zero_pulses", zpulses - z0 === 8);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'h00AB;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rc_in_compute", {busy, fir_data} === {1'b1, 16'h00AB});
    chk("rc_out_data_before", out_data === 32'h0000_0005);
    reset = 1'b0;
    #1;
    chk("rc_flags", {in_ready, fir_buff_en, fir_en, out_valid, primed, busy} === 6'd0);
    chk("rc_data", {fir_data, out_data} === 48'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rc_release", {in_ready, out_valid, busy} === 3'b101);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
